// File: rtl/planificador_rr_azules_pkg.sv
// Shared definitions for the yellow->blue crossbar schedulers: FSM state
// encoding and the position of the class/dest fields in a crossbar word.
package planificador_rr_azules_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    STALL = 2'd2
  } state_t;

  // Field positions for the reference 12-bit word. Wider or narrower words
  // keep the fields anchored to the MSB, so users offset by (DATA_W - REF_W).
  localparam int REF_W    = 12;
  localparam int CLASS_HI = REF_W - 1;
  localparam int DEST_HI  = REF_W - 3;
  localparam int DEST_LO  = REF_W - 4;

  // One-hot decode of a 2-bit index.
  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/planificador_rr_azules_if.sv
// Bus between the scheduler and the surrounding yellow/blue FIFOs.
//
// Handshake: a yellow FIFO offers its head word whenever fifo_empty[i]=0
// (valid); a blue FIFO accepts whenever almost_full[d]=0 (ready). A transfer
// happens only in a cycle where pop[i] and push[d] are both high; the head
// word is on data_out in that same cycle and both FIFOs act on the next
// rising clock edge. pop/push are never high without a matching partner.
interface planificador_rr_azules_if #(
  parameter int DATA_W  = 12,
  parameter int STALL_W = 8
);
  logic              Enable;
  logic [3:0]        fifo_empty;
  logic [DATA_W-1:0] data_in_p0;
  logic [DATA_W-1:0] data_in_p1;
  logic [DATA_W-1:0] data_in_p2;
  logic [DATA_W-1:0] data_in_p3;
  logic [3:0]        almost_full;
  logic [3:0]        pop;
  logic [3:0]        push;
  logic [DATA_W-1:0] data_out;
  logic [1:0]        grant_idx;
  logic              stalled;
  logic [STALL_W-1:0] stall_count;

  // Environment side: FIFOs and control drive the scheduler inputs.
  modport master (
    output Enable, fifo_empty, data_in_p0, data_in_p1, data_in_p2, data_in_p3,
           almost_full,
    input  pop, push, data_out, grant_idx, stalled, stall_count
  );

  // Scheduler side.
  modport slave (
    input  Enable, fifo_empty, data_in_p0, data_in_p1, data_in_p2, data_in_p3,
           almost_full,
    output pop, push, data_out, grant_idx, stalled, stall_count
  );
endinterface

// File: rtl/planificador_rr_azules_rr_elegir4.sv
// Combinational 4-way rotating priority encoder. Scans ptr+1, ptr+2, ptr+3
// and finally ptr itself, granting the first requester found.
module rr_elegir4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [3:0] gnt,
  output logic       valid
);

  logic found;

  // Rotating scan starting just after the current pointer.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    valid = |req;
    for (int k = 1; k <= 4; k++) begin
      if (!found && req[2'(ptr + 2'(k))]) begin
        gnt[2'(ptr + 2'(k))] = 1'b1;
        found                = 1'b1;
      end
    end
  end

endmodule

// File: rtl/planificador_rr_azules.sv
// Round-robin scheduler sharing the yellow->blue crossbar path among the four
// yellow FIFOs. At most one word moves per cycle; the current holder keeps the
// path for up to QUANTUM consecutive pops before the grant rotates.
module planificador_rr_azules
  import planificador_rr_azules_pkg::*;
#(
  parameter int DATA_W  = 12,
  parameter int QUANTUM = 4,
  parameter int STALL_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  planificador_rr_azules_if.slave  bus,
  output state_t                   fsm_state
);

  localparam int                 DLO       = DEST_LO + (DATA_W - REF_W);
  localparam logic [3:0]         QMAX      = 4'(QUANTUM - 1);
  localparam logic [STALL_W-1:0] STALL_MAX = '1;

  logic [DATA_W-1:0]  head [4];
  logic [1:0]         dest [4];
  logic [3:0]         elig;
  logic [3:0]         scan_gnt;
  logic               scan_valid;
  logic               keep;
  logic [3:0]         sel_oh;
  logic [1:0]         sel_idx;
  logic               xfer;
  logic [1:0]         ptr;
  logic [3:0]         qcnt;
  logic [STALL_W-1:0] stall_cnt;
  state_t             state;
  state_t             next_state;

  assign head[0] = bus.data_in_p0;
  assign head[1] = bus.data_in_p1;
  assign head[2] = bus.data_in_p2;
  assign head[3] = bus.data_in_p3;

  // A source is eligible when it has a word and that word's blue target has room.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      dest[i] = head[i][DLO +: 2];
      elig[i] = !bus.fifo_empty[i] && !bus.almost_full[dest[i]];
    end
  end

  rr_elegir4 u_elegir (
    .req   (elig),
    .ptr   (ptr),
    .gnt   (scan_gnt),
    .valid (scan_valid)
  );

  // Holder keeps the path while it has quantum left; otherwise the rotating
  // scan decides, which ends on ptr so a lone holder is re-granted.
  assign keep   = elig[ptr] && (qcnt < QMAX);
  assign sel_oh = keep ? onehot4(ptr) : scan_gnt;
  assign xfer   = bus.Enable && !reset && scan_valid;

  // Encode the selected one-hot source to an index.
  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < 4; i++) begin
      if (sel_oh[i]) sel_idx = 2'(i);
    end
  end

  // FSM state register and saturating stall counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      stall_cnt <= '0;
    end else if (bus.Enable) begin
      state <= next_state;
      if (next_state == STALL && stall_cnt != STALL_MAX) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end

  // Next state classifies the current cycle from the live inputs.
  always_comb begin
    next_state = IDLE;
    if (&bus.fifo_empty) next_state = IDLE;
    else if (scan_valid) next_state = XFER;
    else                 next_state = STALL;
  end

  // Mealy outputs: pop, push and the data mux all follow the same-cycle grant.
  always_comb begin
    bus.pop      = '0;
    bus.push     = '0;
    bus.data_out = '0;
    if (xfer) begin
      bus.pop      = sel_oh;
      bus.push     = onehot4(dest[sel_idx]);
      bus.data_out = head[sel_idx];
    end
  end

  // Grant pointer and burst quantum counter update on each transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr  <= '0;
      qcnt <= '0;
    end else if (xfer) begin
      if (sel_idx == ptr) begin
        qcnt <= (qcnt < QMAX) ? qcnt + 4'd1 : 4'd0;
      end else begin
        ptr  <= sel_idx;
        qcnt <= 4'd0;
      end
    end
  end

  assign bus.grant_idx   = ptr;
  assign bus.stalled     = (state == STALL);
  assign bus.stall_count = stall_cnt;
  assign fsm_state       = state;

endmodule

// File: tb/tb_planificador_rr_azules.sv
// Bench for planificador_rr_azules: yellow FIFOs are modelled as queues, a
// behavioural round-robin model predicts every cycle's grant, and outputs are
// compared #1 after the falling edge.
module tb_planificador_rr_azules;
  import planificador_rr_azules_pkg::*;

  localparam int DATA_W    = 12;
  localparam int QUANTUM   = 4;
  localparam int STALL_W   = 8;
  localparam int STALL_SAT = (1 << STALL_W) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  planificador_rr_azules_if #(.DATA_W(DATA_W), .STALL_W(STALL_W)) bus ();
  state_t fsm_state;

  planificador_rr_azules #(.DATA_W(DATA_W), .QUANTUM(QUANTUM), .STALL_W(STALL_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .fsm_state (fsm_state)
  );

  // ---------------- environment and model state ----------------
  logic [DATA_W-1:0] yq [4][$];
  logic [DATA_W-1:0] exp_q [$];
  logic [3:0]        af;
  logic              en;
  int                holder, burst, stall_m, cls_m;
  bit                known;
  int                checks, errors;
  int                xfers_seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] mk(input int d);
    logic [1:0] d2;
    d2 = 2'(d);
    return {2'($urandom), d2, 8'($urandom)};
  endfunction

  function automatic int dest_of(input logic [DATA_W-1:0] w);
    return int'(w[9:8]);
  endfunction

  // ---------------- driver ----------------
  task automatic drive();
    logic [DATA_W-1:0] h [4];
    for (int i = 0; i < 4; i++) begin
      h[i] = (yq[i].size() > 0) ? yq[i][0] : DATA_W'($urandom);
      bus.fifo_empty[i] = (yq[i].size() == 0);
    end
    bus.data_in_p0  = h[0];
    bus.data_in_p1  = h[1];
    bus.data_in_p2  = h[2];
    bus.data_in_p3  = h[3];
    bus.almost_full = af;
    bus.Enable      = en;
  endtask

  // One clock cycle: drive, predict, compare, then advance model at the edge.
  task automatic cycle();
    bit [3:0]          e;
    int                src, cls, j;
    logic [3:0]        exp_pop, exp_push;
    logic [DATA_W-1:0] word;
    bit                any_pending;
    drive();
    #1;
    src = -1;
    any_pending = 0;
    for (int i = 0; i < 4; i++) begin
      e[i] = (yq[i].size() > 0) && !af[dest_of(yq[i][0])];
      if (yq[i].size() > 0) any_pending = 1;
    end
    cls = !any_pending ? 0 : (e != 0) ? 1 : 2;
    if (!reset && en && e != 0) begin
      if (e[holder] && burst < QUANTUM - 1) src = holder;
      else begin
        for (int k = 1; k <= 4; k++) begin
          j = (holder + k) % 4;
          if (src < 0 && e[j]) src = j;
        end
      end
    end
    exp_pop  = '0;
    exp_push = '0;
    word     = '0;
    if (src >= 0) begin
      word     = yq[src][0];
      exp_pop  = 4'b0001 << src;
      exp_push = 4'b0001 << dest_of(word);
      exp_q.push_back(word);
    end
    check("pop", bus.pop, exp_pop);
    check("push", bus.push, exp_push);
    if (bus.push != 0) begin
      if (exp_q.size() > 0) check("data_out", bus.data_out, exp_q.pop_front());
      else check("unexpected_push", bus.push, 0);
    end else begin
      check("data_out_idle", bus.data_out, 0);
    end
    if (bus.pop != 0) xfers_seen++;
    if (known) begin
      check("grant_idx", bus.grant_idx, holder);
      check("stalled", bus.stalled, (cls_m == 2));
      check("stall_count", bus.stall_count, stall_m);
      check("fsm_state", fsm_state, cls_m);
    end
    @(posedge clk);
    if (reset) begin
      holder = 0; burst = 0; stall_m = 0; cls_m = 0; known = 1;
    end else if (en) begin
      cls_m = cls;
      if (cls == 2 && stall_m < STALL_SAT) stall_m++;
      if (src >= 0) begin
        if (src == holder) burst = (burst < QUANTUM - 1) ? burst + 1 : 0;
        else begin
          holder = src;
          burst  = 0;
        end
        void'(yq[src].pop_front());
      end
    end
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int left;
    checks = 0; errors = 0; known = 0; xfers_seen = 0;
    holder = 0; burst = 0; stall_m = 0; cls_m = 0;
    reset = 1'b1; en = 1'b1; af = '0;
    @(negedge clk);

    // Reset with p2 holding a dest=1 word: nothing moves until release.
    yq[2].push_back(mk(1));
    run(2);
    reset = 1'b0;
    cycle();
    check("t1_p2_drained", yq[2].size(), 0);

    // Two sources, six dest-0 words each: quantum bursts alternate.
    for (int i = 0; i < 6; i++) begin
      yq[0].push_back(mk(0));
      yq[1].push_back(mk(0));
    end
    xfers_seen = 0;
    run(12);
    check("t2_xfer_cycles", xfers_seen, 12);
    run(1);

    // Single source with ten words: popped every cycle despite quantum.
    for (int i = 0; i < 10; i++) yq[3].push_back(mk(i % 4));
    xfers_seen = 0;
    run(10);
    check("t3_xfer_cycles", xfers_seen, 10);
    check("t3_grant_idx", bus.grant_idx, 3);

    // Blocked dest for five cycles, then released in the same cycle.
    yq[0].push_back(mk(2));
    af = 4'b0100;
    run(5);
    check("t4_stall_count", bus.stall_count, 5);
    check("t4_stalled", bus.stalled, 1);
    af = 4'b0000;
    run(2);

    // Blocked p1 must not hold up p2.
    yq[1].push_back(mk(3));
    yq[2].push_back(mk(0));
    af = 4'b1000;
    cycle();
    check("t5_p2_taken", yq[2].size(), 0);
    af = 4'b0000;
    run(2);

    // Freeze mid-burst, then resume; then saturate the stall counter.
    for (int i = 0; i < 8; i++) yq[0].push_back(mk(1));
    run(2);
    en = 1'b0;
    run(3);
    check("t6_frozen_depth", yq[0].size(), 6);
    en = 1'b1;
    run(7);
    yq[0].push_back(mk(1));
    af = 4'b0010;
    run(260);
    check("t6_stall_sat", bus.stall_count, STALL_SAT);
    af = 4'b0000;
    run(2);

    // Randomized traffic with backpressure, freezes and occasional resets.
    for (int n = 0; n < 500; n++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 2) == 0 && yq[i].size() < 6) yq[i].push_back(mk($urandom_range(0, 3)));
      end
      af    = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
      en    = ($urandom_range(0, 9) != 0);
      reset = ($urandom_range(0, 99) == 0);
      cycle();
    end
    reset = 1'b0; en = 1'b1; af = '0;

    // Drain, bounded.
    left = 0;
    for (int n = 0; n < 100; n++) begin
      left = yq[0].size() + yq[1].size() + yq[2].size() + yq[3].size();
      if (left != 0) cycle();
    end
    left = yq[0].size() + yq[1].size() + yq[2].size() + yq[3].size();
    check("drain_words_left", left, 0);
    check("scoreboard_leftover", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
